// File: rtl/mul_array_sched.sv
// rtl/mul_array_sched.sv - sequencer for the replicated a_b_mul array with trigger window
module mul_array_sched #(
  parameter int NUM_INST = 100,
  parameter int W        = 12,
  parameter int SETUP    = 2,
  parameter int MUL_LAT  = 3,
  parameter int GAP      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [NUM_INST-1:0] cfg_mask,
  input  logic                op_valid,
  input  logic [W-1:0]        op_a,
  input  logic [W-1:0]        op_b,
  output logic                op_ready,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  output logic [NUM_INST-1:0] mul_en,
  output logic                mul_start,
  input  logic [W-1:0]        mul_res,
  output logic                res_valid,
  output logic [W-1:0]        res_out,
  output logic                trig,
  output logic                busy,
  output logic [15:0]         op_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_FIRE  = 3'd2,
    S_WAIT  = 3'd3,
    S_CAPT  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // Counter reload values; each state exits when cnt reaches zero.
  // The CAPT cycle is already the first quiet cycle after the capture edge,
  // so the GAP state itself only lasts GAP-1 cycles.
  localparam logic [7:0] SETUP_LD = 8'(SETUP - 1);
  localparam logic [7:0] WAIT_LD  = 8'(MUL_LAT - 1);
  localparam logic [7:0] GAP_LD   = (GAP >= 2) ? 8'(GAP - 2) : 8'd0;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       xfer;
  logic       capture;

  assign xfer    = op_valid & op_ready;
  assign capture = (state == S_WAIT) && (cnt == 8'd0);

  // State and phase counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic and per-state control outputs
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    op_ready  = 1'b0;
    mul_start = 1'b0;
    res_valid = 1'b0;
    trig      = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy     = 1'b0;
        op_ready = !rst;
        if (xfer) begin
          state_nx = S_SETUP;
          cnt_nx   = SETUP_LD;
        end
      end
      S_SETUP: begin
        trig = 1'b1;
        if (cnt == 8'd0) state_nx = S_FIRE;
        else             cnt_nx   = cnt - 8'd1;
      end
      S_FIRE: begin
        trig      = 1'b1;
        mul_start = 1'b1;
        state_nx  = S_WAIT;
        cnt_nx    = WAIT_LD;
      end
      S_WAIT: begin
        trig = 1'b1;
        if (cnt == 8'd0) state_nx = S_CAPT;
        else             cnt_nx   = cnt - 8'd1;
      end
      S_CAPT: begin
        res_valid = 1'b1;
        if (GAP >= 2) begin
          state_nx = S_GAP;
          cnt_nx   = GAP_LD;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt == 8'd0) state_nx = S_IDLE;
        else             cnt_nx   = cnt - 8'd1;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // Operand latch, enable mask, result capture and completed-op counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_en  <= '1;
      res_out <= '0;
      op_cnt  <= 16'd0;
    end else begin
      if (xfer) begin
        mul_a <= op_a;
        mul_b <= op_b;
      end
      if (cfg_we && (state == S_IDLE)) mul_en <= cfg_mask;
      if (capture) res_out <= mul_res;
      if (state == S_CAPT) op_cnt <= op_cnt + 16'd1;
    end
  end

endmodule
